// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, hazard bit indices and state encoding for the fetch stage
package fetch_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int PIPE_ID = 3;
  localparam int PIPE_EX = 2;
  localparam int PIPE_MEM = 1;
  typedef enum logic [1:0] {FETCH, WAIT, KILL} state_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: one-entry skid buffer holding a fetched {pc, inst} the ID register could not take
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      pc <= '0;
      inst <= NOP;
    end else if (load) begin
      valid <= 1'b1;
      pc <= load_pc;
      inst <= load_inst;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with one outstanding imem request, redirect/trap kill, skid buffer and IF/ID register
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_pause,
  input  logic [3:0]  pipe_pause,
  input  logic [3:0]  pipe_bubble,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        trap_valid,
  input  logic [31:0] trap_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);
  state_t state;
  logic [31:0] pc, req_pc, tgt, buf_pc, buf_inst;
  logic buf_valid, redir, fire, resp, done, stall_id, unused;
  always_comb begin
    redir = trap_valid || redirect_valid;
    tgt = trap_valid ? trap_pc : redirect_pc;
    imem_req = !rst && state == FETCH && !pc_pause && !buf_valid;
    imem_addr = pc;
    fire = imem_req && imem_gnt;
    resp = state == WAIT && imem_rvalid;
    done = state != FETCH && imem_rvalid;
    stall_id = pipe_bubble[PIPE_ID] || pipe_pause[PIPE_ID];
  end
  assign unused = ^{pipe_pause[2:0], pipe_bubble[2:0]};
  fetch_buf u_buf (
    .clk(clk),
    .rst(rst),
    .load(resp && !redir && stall_id),
    .drain(buf_valid && !redir && !stall_id),
    .clear(redir),
    .load_pc(req_pc),
    .load_inst(imem_rdata),
    .valid(buf_valid),
    .pc(buf_pc),
    .inst(buf_inst)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      req_pc <= '0;
      id_valid <= 1'b0;
      id_pc <= '0;
      id_inst <= NOP;
    end else begin
      state <= fire ? (redir ? KILL : WAIT) : done ? FETCH : (redir && state == WAIT) ? KILL : state;
      pc <= redir ? {tgt[31:2], 2'b00} : fire ? pc + 32'd4 : pc;
      if (fire) req_pc <= pc;
      if (redir || pipe_bubble[PIPE_ID]) begin
        id_valid <= 1'b0;
        id_inst <= NOP;
      end else if (!pipe_pause[PIPE_ID]) begin
        id_valid <= buf_valid || resp;
        id_pc <= buf_valid ? buf_pc : resp ? req_pc : id_pc;
        id_inst <= buf_valid ? buf_inst : resp ? imem_rdata : NOP;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, pc_pause = 1'b0;
  logic [3:0] pipe_pause = 4'b0, pipe_bubble = 4'b0;
  logic redirect_valid = 1'b0, trap_valid = 1'b0;
  logic [31:0] redirect_pc = '0, trap_pc = '0;
  logic imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic id_valid;
  logic [31:0] id_pc, id_inst;
  int n_cmp = 0, n_bad = 0;
  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_pause(pc_pause), .pipe_pause(pipe_pause), .pipe_bubble(pipe_bubble),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_pc(trap_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_idv", 32'(id_valid), 0);
    chk("rst_idpc", id_pc, 0);
    chk("rst_inst", id_inst, 32'h13);
    rst = 0; imem_gnt = 1;
    #1;
    chk("a_req", 32'(imem_req), 1);
    chk("a_addr", imem_addr, 32'h8000_0000);
    tick;
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h93;
    #1;
    chk("a_wait_req", 32'(imem_req), 0);
    tick;
    imem_rvalid = 0;
    chk("a_idv", 32'(id_valid), 1);
    chk("a_idpc", id_pc, 32'h8000_0000);
    chk("a_inst", id_inst, 32'h93);
    chk("a_next", imem_addr, 32'h8000_0004);
    chk("a_next_req", 32'(imem_req), 1);
    imem_gnt = 1; pipe_pause = 4'b1000;
    tick;
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h113;
    tick;
    imem_rvalid = 0;
    #1;
    chk("b_hold_pc", id_pc, 32'h8000_0000);
    chk("b_hold_inst", id_inst, 32'h93);
    chk("b_full_req", 32'(imem_req), 0);
    tick;
    pipe_pause = 0;
    #1;
    chk("b_full_req2", 32'(imem_req), 0);
    chk("b_hold_inst2", id_inst, 32'h93);
    tick;
    chk("b_idv", 32'(id_valid), 1);
    chk("b_idpc", id_pc, 32'h8000_0004);
    chk("b_inst", id_inst, 32'h113);
    chk("b_req", 32'(imem_req), 1);
    chk("b_addr", imem_addr, 32'h8000_0008);
    imem_gnt = 1;
    tick;
    imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h8000_0102;
    tick;
    redirect_valid = 0;
    #1;
    chk("c_kill_req", 32'(imem_req), 0);
    chk("c_idv", 32'(id_valid), 0);
    chk("c_inst", id_inst, 32'h13);
    imem_rvalid = 1; imem_rdata = 32'hdead_beef;
    tick;
    imem_rvalid = 0;
    #1;
    chk("c_idv2", 32'(id_valid), 0);
    chk("c_inst2", id_inst, 32'h13);
    chk("c_req", 32'(imem_req), 1);
    chk("c_addr", imem_addr, 32'h8000_0100);
    trap_valid = 1; trap_pc = 32'h40; redirect_valid = 1; redirect_pc = 32'h8000_0200;
    tick;
    trap_valid = 0; redirect_valid = 0;
    #1;
    chk("d_addr", imem_addr, 32'h40);
    chk("d_req", 32'(imem_req), 1);
    redirect_valid = 1; redirect_pc = 32'hffff_ffff;
    tick;
    redirect_valid = 0;
    #1;
    chk("e_addr", imem_addr, 32'hffff_fffc);
    imem_gnt = 1;
    tick;
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h213; pipe_bubble = 4'b1000;
    tick;
    imem_rvalid = 0; pipe_bubble = 0;
    #1;
    chk("e_bub_idv", 32'(id_valid), 0);
    chk("e_bub_inst", id_inst, 32'h13);
    chk("e_full_req", 32'(imem_req), 0);
    chk("e_wrap", imem_addr, 32'h0);
    tick;
    chk("e_idv", 32'(id_valid), 1);
    chk("e_idpc", id_pc, 32'hffff_fffc);
    chk("e_inst", id_inst, 32'h213);
    chk("e_req", 32'(imem_req), 1);
    imem_gnt = 1; redirect_valid = 1; redirect_pc = 32'h8000_0300;
    tick;
    imem_gnt = 0; redirect_valid = 0;
    #1;
    chk("f_kill_req", 32'(imem_req), 0);
    imem_rvalid = 1; imem_rdata = 32'hbad;
    tick;
    imem_rvalid = 0;
    #1;
    chk("f_idv", 32'(id_valid), 0);
    chk("f_addr", imem_addr, 32'h8000_0300);
    pc_pause = 1; imem_gnt = 1;
    #1;
    chk("g_pause_req", 32'(imem_req), 0);
    tick;
    chk("g_pause_addr", imem_addr, 32'h8000_0300);
    pc_pause = 0;
    tick;
    imem_gnt = 0; rst = 1;
    tick;
    rst = 0;
    #1;
    chk("h_req", 32'(imem_req), 1);
    chk("h_addr", imem_addr, 32'h8000_0000);
    chk("h_idv", 32'(id_valid), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
